// File: rtl/taillight_sequencer.sv
// Rear-lamp controller: sequential turn sweep, hazard blink, brake and fog per cluster.
// Optional SWEEP_HOLD_EN holds the full sweep pattern for one extra animation tick.
module taillight_sequencer #(
  parameter int LAMPS    = 3,
  parameter int TICK_DIV = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             left,
  input  logic             right,
  input  logic             brake,
  input  logic             hazard,
  input  logic             fog,
  output logic [LAMPS-1:0] l_lamps,
  output logic [LAMPS-1:0] r_lamps,
  output logic             haz_active
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PW = $clog2(LAMPS + 1);

  typedef enum logic [2:0] {ModeOff, ModeTurn, ModeHaz, ModeBrake, ModeFog} mode_e;

  logic [CW-1:0] cnt;
  logic          tick;
  mode_e         mode_q [2];
  mode_e         mode_d [2];
  logic [PW-1:0] pos_q  [2];
  logic [PW-1:0] pos_d  [2];
  logic          phase_q, phase_d;
  logic          haz_req;
  logic [1:0]    turn_req;
  logic [LAMPS-1:0] lamps [2];
`ifdef SWEEP_HOLD_EN
  logic          hold_q [2];
  logic          hold_d [2];
`endif

  assign tick     = (cnt == CW'(TICK_DIV - 1));
  assign haz_req  = hazard | (left & right);
  assign turn_req = {right, left};

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      if (haz_req)          mode_d[s] = ModeHaz;
      else if (turn_req[s]) mode_d[s] = ModeTurn;
      else if (brake)       mode_d[s] = ModeBrake;
      else if (fog)         mode_d[s] = ModeFog;
      else                  mode_d[s] = ModeOff;

      // Sweep only advances while staying in TURN; entry and exit both restart at 0.
      pos_d[s] = '0;
`ifdef SWEEP_HOLD_EN
      hold_d[s] = 1'b0;
`endif
      if (mode_d[s] == ModeTurn && mode_q[s] == ModeTurn) begin
        pos_d[s] = pos_q[s];
`ifdef SWEEP_HOLD_EN
        hold_d[s] = hold_q[s];
`endif
        if (tick) begin
          if (pos_q[s] == PW'(LAMPS)) begin
`ifdef SWEEP_HOLD_EN
            if (!hold_q[s]) begin
              hold_d[s] = 1'b1;
            end else begin
              pos_d[s]  = '0;
              hold_d[s] = 1'b0;
            end
`else
            pos_d[s] = '0;
`endif
          end else begin
            pos_d[s] = pos_q[s] + PW'(1);
          end
        end
      end
    end

    // Hazard is always entered on both sides together, so one phase bit serves both.
    phase_d = (mode_d[0] == ModeHaz && mode_q[0] == ModeHaz) ? (phase_q ^ tick) : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      phase_q <= 1'b0;
      for (int s = 0; s < 2; s++) begin
        mode_q[s] <= ModeOff;
        pos_q[s]  <= '0;
`ifdef SWEEP_HOLD_EN
        hold_q[s] <= 1'b0;
`endif
      end
    end else begin
      cnt     <= tick ? '0 : cnt + CW'(1);
      phase_q <= phase_d;
      for (int s = 0; s < 2; s++) begin
        mode_q[s] <= mode_d[s];
        pos_q[s]  <= pos_d[s];
`ifdef SWEEP_HOLD_EN
        hold_q[s] <= hold_d[s];
`endif
      end
    end
  end

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      lamps[s] = '0;
      unique case (mode_q[s])
        ModeTurn: begin
          for (int i = 0; i < LAMPS; i++) lamps[s][i] = (PW'(i) < pos_q[s]);
        end
        ModeHaz:   lamps[s] = {LAMPS{phase_q}};
        ModeBrake: lamps[s] = '1;
        ModeFog:   lamps[s][0] = 1'b1;
        default:   lamps[s] = '0;
      endcase
    end
  end

  assign l_lamps    = lamps[0];
  assign r_lamps    = lamps[1];
  assign haz_active = (mode_q[0] == ModeHaz) && (mode_q[1] == ModeHaz);

endmodule

// File: tb/tb_taillight_sequencer.sv
// Directed self-checking bench for taillight_sequencer; three instances cover
// the default, prescaled and four-lamp configurations.
module tb_taillight_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Instance A: LAMPS=3, TICK_DIV=1
  logic reset, left, right, brake, hazard, fog;
  logic [2:0] l_lamps, r_lamps;
  logic haz_active;

  // Instance B: LAMPS=3, TICK_DIV=4
  logic rst_b, right_b;
  logic [2:0] l_lamps_b, r_lamps_b;
  logic haz_b;

  // Instance C: LAMPS=4, TICK_DIV=1
  logic rst_c, left_c;
  logic [3:0] l_lamps_c, r_lamps_c;
  logic haz_c;

  taillight_sequencer #(.LAMPS(3), .TICK_DIV(1)) dut_a (
    .clk(clk), .reset(reset), .left(left), .right(right), .brake(brake),
    .hazard(hazard), .fog(fog), .l_lamps(l_lamps), .r_lamps(r_lamps),
    .haz_active(haz_active)
  );

  taillight_sequencer #(.LAMPS(3), .TICK_DIV(4)) dut_b (
    .clk(clk), .reset(rst_b), .left(1'b0), .right(right_b), .brake(1'b0),
    .hazard(1'b0), .fog(1'b0), .l_lamps(l_lamps_b), .r_lamps(r_lamps_b),
    .haz_active(haz_b)
  );

  taillight_sequencer #(.LAMPS(4), .TICK_DIV(1)) dut_c (
    .clk(clk), .reset(rst_c), .left(left_c), .right(1'b0), .brake(1'b0),
    .hazard(1'b0), .fog(1'b0), .l_lamps(l_lamps_c), .r_lamps(r_lamps_c),
    .haz_active(haz_c)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [2:0] l, input logic [2:0] r,
                       input logic h);
    chk({tag, ".l"}, 8'(l_lamps), 8'(l));
    chk({tag, ".r"}, 8'(r_lamps), 8'(r));
    chk({tag, ".haz"}, 8'(haz_active), 8'(h));
  endtask

  logic [3:0] exp_c [7];

  initial begin
    reset = 1'b1; left = 1'b0; right = 1'b0; brake = 1'b0; hazard = 1'b0; fog = 1'b0;
    rst_b = 1'b1; right_b = 1'b0;
    rst_c = 1'b1; left_c = 1'b0;

    // Reset state
    step();
    chk_a("reset", 3'b000, 3'b000, 1'b0);

    // Left sweep, period LAMPS+1
    reset = 1'b0; left = 1'b1;
    step(); chk_a("sweep1", 3'b000, 3'b000, 1'b0);
    step(); chk_a("sweep2", 3'b001, 3'b000, 1'b0);
    step(); chk_a("sweep3", 3'b011, 3'b000, 1'b0);
    step(); chk_a("sweep4", 3'b111, 3'b000, 1'b0);
    step(); chk_a("sweep5", 3'b000, 3'b000, 1'b0);
    step(); chk_a("sweep6", 3'b001, 3'b000, 1'b0);

    // Left turn with brake: right side brakes, left keeps sweeping
    reset = 1'b1; step();
    reset = 1'b0; brake = 1'b1;
    step(); chk_a("lbrk1", 3'b000, 3'b111, 1'b0);
    step(); chk_a("lbrk2", 3'b001, 3'b111, 1'b0);
    step(); chk_a("lbrk3", 3'b011, 3'b111, 1'b0);
    left = 1'b0;
    step(); chk_a("lbrk_drop", 3'b111, 3'b111, 1'b0);

    // Hazard blink then fog
    brake = 1'b0; hazard = 1'b1;
    step(); chk_a("haz1", 3'b000, 3'b000, 1'b1);
    step(); chk_a("haz2", 3'b111, 3'b111, 1'b1);
    step(); chk_a("haz3", 3'b000, 3'b000, 1'b1);
    step(); chk_a("haz4", 3'b111, 3'b111, 1'b1);
    hazard = 1'b0; fog = 1'b1;
    step(); chk_a("haz_fog", 3'b001, 3'b001, 1'b0);

    // Both turn requests behave as hazard
    left = 1'b1; right = 1'b1;
    step(); chk_a("both1", 3'b000, 3'b000, 1'b1);
    step(); chk_a("both2", 3'b111, 3'b111, 1'b1);
    left = 1'b0; right = 1'b0; fog = 1'b0;
    step(); chk_a("both_off", 3'b000, 3'b000, 1'b0);

    // Right-only sweep, left stays dark
    right = 1'b1;
    step(); chk_a("rsw1", 3'b000, 3'b000, 1'b0);
    step(); chk_a("rsw2", 3'b000, 3'b001, 1'b0);
    right = 1'b0;

    // Reset mid-sweep restarts the animation
    left = 1'b1;
    step(); chk_a("mid1", 3'b000, 3'b000, 1'b0);
    step(); chk_a("mid2", 3'b001, 3'b000, 1'b0);
    step(); chk_a("mid3", 3'b011, 3'b000, 1'b0);
    reset = 1'b1;
    step(); chk_a("mid_rst", 3'b000, 3'b000, 1'b0);
    reset = 1'b0;
    step(); chk_a("mid_re1", 3'b000, 3'b000, 1'b0);
    step(); chk_a("mid_re2", 3'b001, 3'b000, 1'b0);
    left = 1'b0;

    // Prescaled sweep on instance B: one step per 4 cycles
    step();
    rst_b = 1'b0; right_b = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      logic [2:0] e;
      step();
      unique case ((k / 4) % 4)
        0: e = 3'b000;
        1: e = 3'b001;
        2: e = 3'b011;
        default: e = 3'b111;
      endcase
      chk($sformatf("div4_r%0d", k), 8'(r_lamps_b), 8'(e));
    end
    chk("div4_l", 8'(l_lamps_b), 8'h00);
    chk("div4_haz", 8'(haz_b), 8'h00);

    // Four-lamp sweep on instance C, with or without the full-pattern hold
`ifdef SWEEP_HOLD_EN
    exp_c = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1111, 4'b0000};
`else
    exp_c = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b0000, 4'b0001};
`endif
    step();
    rst_c = 1'b0; left_c = 1'b1;
    for (int k = 0; k < 7; k++) begin
      step();
      chk($sformatf("l4_sweep%0d", k + 1), 8'(l_lamps_c), 8'(exp_c[k]));
    end
    chk("l4_r", 8'(r_lamps_c), 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/taillight_sequencer.md
Name: taillight_sequencer

Overview:
- Parametrised rear-lamp controller for the left and right clusters, each with LAMPS lamps.
- Provides sequential turn sweep, hazard blink (also entered when both turn requests are active), steady brake and a single-lamp fog indication.
- Animation advances on a prescaled tick, so one block serves both simulation (TICK_DIV=1) and board clocks.
- Sits between the dashboard switch synchroniser and the lamp driver pins.

Parameters:
- LAMPS, 3, lamps per side, legal 2..8. Index 0 is the innermost lamp.
- TICK_DIV, 1, clk cycles per animation step, legal >=1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- left  in  1  left turn request, level
- right  in  1  right turn request, level
- brake  in  1  brake pedal, level
- hazard  in  1  hazard switch, level
- fog  in  1  fog lamp switch, level
- l_lamps  out  LAMPS  left cluster, bit i = lamp i
- r_lamps  out  LAMPS  right cluster
- haz_active  out  1  high while both sides are in HAZ mode

Behaviour:
- Reset is synchronous, active-high; clock is clk. Reset (also mid-sequence) clears: prescaler cnt=0, both modes=OFF, both pos=0, phase=0. All outputs are 0 in the cycle after the reset edge.
- Prescaler:
  - Free-running cnt runs 0..TICK_DIV-1 and is independent of mode.
  - tick = (cnt==TICK_DIV-1), i.e. a tick every cycle when TICK_DIV=1.
  - Counter width is max(1,$clog2(TICK_DIV)).
- Mode, per side, evaluated every edge from the current inputs. First match wins:
  - 1. hazard | (left & right) -> HAZ (both sides)
  - 2. own turn input -> TURN
  - 3. brake -> BRAKE
  - 4. fog -> FOG
  - 5. otherwise OFF
  - Example: left & brake gives left=TURN, right=BRAKE.
- The mode register updates every edge. Input-to-lamp latency is 1 cycle.
- Outputs are a combinational decode of registered mode/pos/phase only. There is no combinational path from the inputs to the outputs.
- TURN state (pos 0..LAMPS, width $clog2(LAMPS+1)):
  - On entry from any other mode: pos<=0.
  - While staying in TURN with tick: pos<=pos+1, wrapping LAMPS->0. Without tick, pos holds.
  - Lamps = thermometer(pos): lamps 0..pos-1 on. Period is LAMPS+1 ticks.
  - On exit: pos<=0 immediately, with no wait for a tick.
- HAZ:
  - On entry: phase<=0.
  - While staying in HAZ with tick: phase toggles.
  - Both sides all ones when phase=1, otherwise zeros; both sides are always identical.
  - haz_active=1.
  - On exit: phase<=0.
- BRAKE: all lamps of that side on, steady.
- FOG: lamp 0 only, steady.
- OFF: all lamps 0.
- Switching TURN<->HAZ restarts the entered animation from pos 0 or phase 0.
- The left and right sweeps share the prescaler but keep independent pos registers.

Optional Feature:
- Macro: SWEEP_HOLD_EN.
- When defined, TURN holds the full pattern for one extra tick: pos sequence is 0,1,..,LAMPS,LAMPS,0, giving a period of LAMPS+2 ticks. This needs a 1-bit hold flag per side, cleared on TURN entry, TURN exit and reset.
- When undefined: sequence is 0..LAMPS,0 with period LAMPS+1, and no hold flag is instantiated.

Test Plan:
- LAMPS=3, TICK_DIV=1, reset then left=1 held -> l_lamps across edges 1..6 = 000,001,011,111,000,001; r_lamps=000 throughout.
- Left=1 with brake=1 -> left sweeps as above while r_lamps=111 from edge 1. Drop left at pos=2 -> l_lamps=111 on the next edge.
- hazard=1 (or left=right=1) -> both sides 000,111,000,111 on consecutive edges; haz_active=1 from edge 1. Drop hazard with brake=0, fog=1 -> both sides 001 next edge, haz_active=0.
- TICK_DIV=4, right=1 from reset -> r_lamps advances only on edges where cnt wraps, i.e. one step per 4 cycles: 000 x3, 001 x4, 011 x4, 111 x4, 000.
- Assert reset while left sweep shows 011 -> outputs 000 next edge. After release, the sweep restarts at 000 then 001.
- SWEEP_HOLD_EN defined, LAMPS=4, TICK_DIV=1, left=1 -> 0000,0001,0011,0111,1111,1111,0000. Undefined -> single 1111, then 0000.
